// File: rtl/async_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// async_pulse_conditioner
//
// Multi-channel front end that brings asynchronous single-bit inputs into the
// clk domain. Each channel has a STAGES-deep synchronizer, a stability filter
// that accepts a new value only after it has held for FILT consecutive cycles,
// and a one-cycle edge pulse whose polarity is selected at runtime.
//
// Optional feature (macro PULSE_COND_STICKY_EN): per-channel sticky event
// flags with individual clear. Without the macro those ports and flops are
// absent and all other behaviour is identical.
//
// Parameters:
//   CH      number of independent channels (>=1)
//   STAGES  synchronizer flops per channel (>=2)
//   FILT    consecutive stable cycles required to accept a new value (>=1)
//   CNT_W   filter counter width (derived, do not override)
//
// Ports:
//   clk        in   1     sole clock
//   rst        in   1     synchronous reset, active-high
//   async_in   in   CH    asynchronous inputs, one bit per channel
//   edge_mode  in   2*CH  per channel [2i+1:2i]: 00 rise, 01 fall, 10 both,
//                         11 disabled; synchronous to clk
//   event_clr  in   CH    sticky clear per channel (PULSE_COND_STICKY_EN only)
//   event_o    out  CH    sticky event flags (PULSE_COND_STICKY_EN only)
//   level_o    out  CH    filtered synchronized level
//   pulse_o    out  CH    one-cycle edge pulse, qualified by edge_mode
// -----------------------------------------------------------------------------
module async_pulse_conditioner #(
    parameter int CH     = 4,
    parameter int STAGES = 2,
    parameter int FILT   = 4,
    parameter int CNT_W  = $clog2(FILT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   async_in,
    input  logic [2*CH-1:0] edge_mode,
`ifdef PULSE_COND_STICKY_EN
    input  logic [CH-1:0]   event_clr,
    output logic [CH-1:0]   event_o,
`endif
    output logic [CH-1:0]   level_o,
    output logic [CH-1:0]   pulse_o
);

    typedef enum logic [1:0] {
        EM_RISE = 2'b00,
        EM_FALL = 2'b01,
        EM_BOTH = 2'b10,
        EM_OFF  = 2'b11
    } edge_mode_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT - 1);

    // Decide whether an accepted level change produces a pulse.
    function automatic logic pulse_qualify(input logic [1:0] mode, input logic new_lvl);
        logic       res;
        edge_mode_e m;
        m   = edge_mode_e'(mode);
        res = 1'b0;
        unique case (m)
            EM_RISE: res = new_lvl;
            EM_FALL: res = ~new_lvl;
            EM_BOTH: res = 1'b1;
            EM_OFF:  res = 1'b0;
        endcase
        return res;
    endfunction

    logic [CH-1:0]    w_sync_q;
    logic [CH-1:0]    w_accept;
    logic [CH-1:0]    w_level_d;
    logic [CH-1:0]    w_pulse_d;
    logic [CNT_W-1:0] w_cnt_d [CH];

    logic [CNT_W-1:0] r_cnt   [CH];
    logic [CH-1:0]    r_level;
    logic [CH-1:0]    r_pulse;

    // -------------------------------------------------------------------------
    // Synchronizer: plain flop chain per channel, nothing between stages.
    // -------------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < CH; g++) begin : g_sync
            logic [STAGES-1:0] r_sync;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], async_in[g]};
                end
            end

            assign w_sync_q[g] = r_sync[STAGES-1];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Stability filter and pulse qualification.
    // The counter tracks consecutive cycles of disagreement between the
    // synchronized value and the accepted level; it is cleared on agreement
    // and on acceptance, so it never exceeds FILT-1.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            w_cnt_d[i]   = '0;
            w_accept[i]  = 1'b0;
            if (w_sync_q[i] != r_level[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_accept[i] = 1'b1;
                end else begin
                    w_cnt_d[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_level_d = r_level ^ w_accept;
        w_pulse_d = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (w_accept[i]) begin
                w_pulse_d[i] = pulse_qualify(edge_mode[2*i +: 2], w_level_d[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_level <= '0;
            r_pulse <= '0;
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
            r_level <= w_level_d;
            r_pulse <= w_pulse_d;
        end
    end

    assign level_o = r_level;
    assign pulse_o = r_pulse;

    // -------------------------------------------------------------------------
    // Sticky event flags: set together with the pulse, set wins over clear.
    // -------------------------------------------------------------------------
`ifdef PULSE_COND_STICKY_EN
    logic [CH-1:0] r_event;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_event <= '0;
        end else begin
            r_event <= (r_event & ~event_clr) | w_pulse_d;
        end
    end

    assign event_o = r_event;
`else
    // No sticky state in this build.
`endif

endmodule

// File: tb/tb_async_pulse_conditioner.sv
`timescale 1ns/1ps
module tb_async_pulse_conditioner;

    localparam int CH     = 4;
    localparam int STAGES = 2;
    localparam int FILT   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   async_in;
    logic [2*CH-1:0] edge_mode;
    logic [CH-1:0]   level_o;
    logic [CH-1:0]   pulse_o;
`ifdef PULSE_COND_STICKY_EN
    logic [CH-1:0]   event_clr;
    logic [CH-1:0]   event_o;
`endif

    always #5 clk = ~clk;

    async_pulse_conditioner #(
        .CH     (CH),
        .STAGES (STAGES),
        .FILT   (FILT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
        .edge_mode (edge_mode),
`ifdef PULSE_COND_STICKY_EN
        .event_clr (event_clr),
        .event_o   (event_o),
`endif
        .level_o   (level_o),
        .pulse_o   (pulse_o)
    );

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] pls;
        logic [CH-1:0] ev;
    } exp_t;

    exp_t sbq [$];
    int   n_chk = 0;
    int   n_err = 0;
    int   pcnt [CH];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [2*CH-1:0] all_mode(input logic [1:0] m);
        return {CH{m}};
    endfunction

    // Reference model: a value is accepted once the last FILT synchronized
    // samples (each the input as seen STAGES edges earlier) all differ from
    // the current level.
    initial begin : model
        logic [CH-1:0] line [STAGES];
        logic [CH-1:0] win [$];
        logic [CH-1:0] lvl;
        logic [CH-1:0] ev;
        logic [CH-1:0] pls;
        logic [CH-1:0] s;
        logic [1:0]    m;
        bit            all_diff;
        lvl = '0;
        ev  = '0;
        for (int k = 0; k < STAGES; k++) line[k] = '0;
        forever begin
            @(posedge clk);
            pls = '0;
            if (rst) begin
                lvl = '0;
                ev  = '0;
                win.delete();
                for (int k = 0; k < STAGES; k++) line[k] = '0;
            end else begin
                s = line[STAGES-1];
                for (int k = STAGES-1; k > 0; k--) line[k] = line[k-1];
                line[0] = async_in;
                win.push_back(s);
                if (win.size() > FILT) void'(win.pop_front());
                for (int i = 0; i < CH; i++) begin
                    all_diff = (win.size() == FILT);
                    for (int j = 0; j < win.size(); j++) begin
                        if (win[j][i] == lvl[i]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        lvl[i] = ~lvl[i];
                        m = edge_mode[2*i +: 2];
                        case (m)
                            2'b00:   pls[i] = lvl[i];
                            2'b01:   pls[i] = ~lvl[i];
                            2'b10:   pls[i] = 1'b1;
                            default: pls[i] = 1'b0;
                        endcase
                    end
                end
`ifdef PULSE_COND_STICKY_EN
                ev = (ev & ~event_clr) | pls;
`endif
            end
            sbq.push_back('{lvl: lvl, pls: pls, ev: ev});
        end
    end

    // Monitor: every cycle the DUT presents level/pulse; pop and compare.
    initial begin : monitor
        exp_t e;
        for (int i = 0; i < CH; i++) pcnt[i] = 0;
        forever begin
            @(negedge clk);
            if (sbq.size() == 0) begin
                check("sb_nonempty", 32'(sbq.size()), 32'd1);
            end else begin
                e = sbq.pop_front();
                check("level", 32'(level_o), 32'(e.lvl));
                check("pulse", 32'(pulse_o), 32'(e.pls));
`ifdef PULSE_COND_STICKY_EN
                check("event", 32'(event_o), 32'(e.ev));
`endif
                for (int i = 0; i < CH; i++) pcnt[i] += int'(pulse_o[i]);
            end
        end
    end

    initial begin : stim
        int base [CH];
        int exp_cnt [3];
        logic [1:0] modes [3];
        rst       = 1'b1;
        async_in  = '1;
        edge_mode = all_mode(2'b00);
`ifdef PULSE_COND_STICKY_EN
        event_clr = '0;
`endif
        tick(1);
        #1;
        check("rst_level", 32'(level_o), 32'h0);
        check("rst_pulse", 32'(pulse_o), 32'h0);
        tick(2);
        rst = 1'b0;

        // Input high through reset: level appears after STAGES+FILT edges.
        tick(5);
        #1 check("rst_hi_pre", 32'(level_o), 32'h0);
        tick(1);
        #1 check("rst_hi_lvl", 32'(level_o), 32'hF);
        check("rst_hi_pls", 32'(pulse_o), 32'hF);
        tick(1);
        #1 check("rst_hi_pls_end", 32'(pulse_o), 32'h0);

        // Glitch filtering on ch0, mode rise.
        async_in[0] = 1'b0;
        tick(12);
        base[0] = pcnt[0];
        async_in[0] = 1'b1;
        tick(3);
        async_in[0] = 1'b0;
        tick(12);
        #1 check("glitch_lvl", 32'(level_o[0]), 32'h0);
        check("glitch_pcnt", 32'(pcnt[0] - base[0]), 32'h0);
        base[0] = pcnt[0];
        async_in[0] = 1'b1;
        tick(5);
        async_in[0] = 1'b0;
        tick(1);
        #1 check("wide_lvl", 32'(level_o[0]), 32'h1);
        tick(12);
        check("wide_pcnt", 32'(pcnt[0] - base[0]), 32'h1);

        // Edge modes on ch1.
        edge_mode[3:2] = 2'b11;
        async_in[1] = 1'b0;
        tick(12);
        modes[0] = 2'b10; exp_cnt[0] = 2;
        modes[1] = 2'b01; exp_cnt[1] = 1;
        modes[2] = 2'b11; exp_cnt[2] = 0;
        for (int k = 0; k < 3; k++) begin
            edge_mode[3:2] = modes[k];
            base[1] = pcnt[1];
            async_in[1] = 1'b1;
            tick(10);
            #1 check("mode_lvl_hi", 32'(level_o[1]), 32'h1);
            async_in[1] = 1'b0;
            tick(12);
            #1 check("mode_lvl_lo", 32'(level_o[1]), 32'h0);
            check("mode_pcnt", 32'(pcnt[1] - base[1]), 32'(exp_cnt[k]));
        end

        // Independence: ch2/ch3 fall together under mode both.
        edge_mode[7:4] = 4'b1010;
        async_in[3:2] = 2'b00;
        tick(6);
        #1 check("indep_pls", 32'(pulse_o), 32'hC);
        check("indep_lvl", 32'(level_o), 32'h0);

        // Reset while ch0's filter counter sits at FILT-1.
        edge_mode[1:0] = 2'b00;
        base[0] = pcnt[0];
        async_in[0] = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        #1 check("midrst_lvl", 32'(level_o[0]), 32'h1);
        check("midrst_pls", 32'(pulse_o[0]), 32'h1);
        tick(4);
        check("midrst_pcnt", 32'(pcnt[0] - base[0]), 32'h1);

`ifdef PULSE_COND_STICKY_EN
        edge_mode[3:2] = 2'b10;
        async_in[1] = 1'b1;
        tick(6);
        #1 check("sticky_set", 32'(event_o[1]), 32'h1);
        tick(5);
        #1 check("sticky_hold", 32'(event_o[1]), 32'h1);
        async_in[1] = 1'b0;
        tick(5);
        event_clr[1] = 1'b1;
        tick(1);
        event_clr[1] = 1'b0;
        #1 check("sticky_setwins_pls", 32'(pulse_o[1]), 32'h1);
        check("sticky_setwins", 32'(event_o[1]), 32'h1);
        tick(2);
        event_clr[1] = 1'b1;
        tick(1);
        event_clr[1] = 1'b0;
        #1 check("sticky_clr", 32'(event_o[1]), 32'h0);
`endif

        // Randomized phase, checked cycle by cycle by the monitor.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 5) == 0) async_in[i] = ~async_in[i];
            end
            if ($urandom_range(0, 15) == 0) edge_mode = (2*CH)'($urandom);
`ifdef PULSE_COND_STICKY_EN
            event_clr = CH'($urandom & $urandom & $urandom);
`endif
        end
        rst = 1'b0;
        tick(20);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
